// File: rtl/fphub_to_ieee_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fphub_to_ieee_stream
//  Description : Streaming HUB -> IEEE-style converter placed after FPHUB_mult.
//                Each HUB word {s, e, m} becomes an exact IEEE-style word
//                {s, e-1, {m, 1'b1}} with M+1 stored mantissa bits. HUB zero
//                and infinity map to their IEEE codes, and a HUB exponent of 0
//                with a non-zero mantissa is flushed to signed zero and
//                flagged as an underflow.
//                The block is a two-stage pipeline with valid/ready handshakes
//                on both sides, full throughput and no word loss.
//
//  Ports       : clk, rst         rising-edge clock, synchronous active-high reset
//                in_valid/in_ready/in_data     upstream handshake, HUB word
//                out_valid/out_ready/out_data  downstream handshake, IEEE word
//                out_uflow        current out_data is an underflow flush
//                cnt_out, cnt_uflow, cnt_clr   saturating status counters,
//                                 present only with FPHUB_STATUS_CNT_EN
//
//  Options     : `define FPHUB_STATUS_CNT_EN adds the status counters.
//
//  Revision    : 1.0  initial release
// ============================================================================
module fphub_to_ieee_stream #(
    parameter int M = 23,
    parameter int E = 8
`ifdef FPHUB_STATUS_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E+M:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [E+M+1:0]   out_data,
    output logic             out_uflow
`ifdef FPHUB_STATUS_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_out,
    output logic [CNT_W-1:0] cnt_uflow,
    input  logic             cnt_clr
`endif
);

    // Decoded class of a HUB word, carried from S1 into S2
    localparam logic [1:0] c_cls_zero  = 2'd0;
    localparam logic [1:0] c_cls_inf   = 2'd1;
    localparam logic [1:0] c_cls_uflow = 2'd2;
    localparam logic [1:0] c_cls_norm  = 2'd3;

    localparam logic [E-1:0] c_exp_one = {{(E-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input field split and classification
    // ------------------------------------------------------------------
    logic         w_in_sign;
    logic [E-1:0] w_in_exp;
    logic [M-1:0] w_in_mant;
    logic [1:0]   w_in_cls;

    assign w_in_sign = in_data[E+M];
    assign w_in_exp  = in_data[E+M-1:M];
    assign w_in_mant = in_data[M-1:0];

    always_comb begin
        w_in_cls = c_cls_norm;
        if ((w_in_exp == '0) && (w_in_mant == '0)) begin
            w_in_cls = c_cls_zero;
        end else if ((&w_in_exp) && (&w_in_mant)) begin
            w_in_cls = c_cls_inf;
        end else if (w_in_exp == '0) begin
            // IEEE exponent would be -1: not representable, flush to zero
            w_in_cls = c_cls_uflow;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic r_s1_v;
    logic r_s2_v;
    logic w_s1_en;
    logic w_s2_en;

    assign w_s2_en  = !r_s2_v || out_ready;
    assign w_s1_en  = !r_s1_v || w_s2_en;
    assign in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // Stage S1: class plus raw fields
    // ------------------------------------------------------------------
    logic [1:0]   r_s1_cls;
    logic         r_s1_sign;
    logic [E-1:0] r_s1_exp;
    logic [M-1:0] r_s1_mant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_cls  <= c_cls_zero;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_mant <= '0;
        end else if (w_s1_en) begin
            r_s1_v <= in_valid;
            // Fields only load with a real word so a bubble leaves them intact
            if (in_valid) begin
                r_s1_cls  <= w_in_cls;
                r_s1_sign <= w_in_sign;
                r_s1_exp  <= w_in_exp;
                r_s1_mant <= w_in_mant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage S2: final IEEE word
    // ------------------------------------------------------------------
    logic [E+M+1:0] w_s2_word;
    logic           w_s2_uflow;
    logic [E+M+1:0] r_s2_data;
    logic           r_s2_uflow;

    always_comb begin
        w_s2_word  = {r_s1_sign, {(E+M+1){1'b0}}};
        w_s2_uflow = 1'b0;
        case (r_s1_cls)
            c_cls_inf: begin
                w_s2_word = {r_s1_sign, {E{1'b1}}, {(M+1){1'b0}}};
            end
            c_cls_uflow: begin
                w_s2_uflow = 1'b1;
            end
            c_cls_norm: begin
                // HUB bias is one larger than IEEE bias; the ILSB becomes explicit
                w_s2_word = {r_s1_sign, r_s1_exp - c_exp_one, r_s1_mant, 1'b1};
            end
            default: begin
                w_s2_word  = {r_s1_sign, {(E+M+1){1'b0}}};
                w_s2_uflow = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v     <= 1'b0;
            r_s2_data  <= '0;
            r_s2_uflow <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            // Output word holds its last value while no new word arrives
            if (r_s1_v) begin
                r_s2_data  <= w_s2_word;
                r_s2_uflow <= w_s2_uflow;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_data  = r_s2_data;
    assign out_uflow = r_s2_uflow;

`ifdef FPHUB_STATUS_CNT_EN
    // ------------------------------------------------------------------
    // Saturating status counters, clear wins over increment
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_out_xfer;
    logic [CNT_W-1:0] r_cnt_out;
    logic [CNT_W-1:0] r_cnt_uflow;

    assign w_out_xfer = r_s2_v && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt_out   <= '0;
            r_cnt_uflow <= '0;
        end else if (w_out_xfer) begin
            if (!(&r_cnt_out)) begin
                r_cnt_out <= r_cnt_out + c_cnt_one;
            end
            if (r_s2_uflow && !(&r_cnt_uflow)) begin
                r_cnt_uflow <= r_cnt_uflow + c_cnt_one;
            end
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_uflow = r_cnt_uflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fphub_to_ieee_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fphub_to_ieee_stream
//  Description : Self-checking bench for fphub_to_ieee_stream (E=8, M=23).
//                Directed vector table plus hand-written sequences for
//                latency, back-pressure, random throughput, mid-flight reset
//                and (with FPHUB_STATUS_CNT_EN) the status counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fphub_to_ieee_stream;

    localparam int M = 23;
    localparam int E = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_data;
    logic        out_uflow;
`ifdef FPHUB_STATUS_CNT_EN
    logic [1:0]  cnt_out;
    logic [1:0]  cnt_uflow;
    logic        cnt_clr;
`endif

    always #5 clk = ~clk;

`ifdef FPHUB_STATUS_CNT_EN
    fphub_to_ieee_stream #(.M(M), .E(E), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_uflow(out_uflow),
        .cnt_out(cnt_out), .cnt_uflow(cnt_uflow), .cnt_clr(cnt_clr)
    );
`else
    fphub_to_ieee_stream #(.M(M), .E(E)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_uflow(out_uflow)
    );
`endif

    typedef struct {
        logic [31:0] din;
        logic [32:0] dout;
        logic        uf;
    } vec_t;

    vec_t        vecs[13];
    logic [33:0] exp_q[$];      // {uflow, data}
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;

    // Reference conversion, written from the number-format definition
    function automatic logic [33:0] model(input logic [31:0] w);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = w[31];
        e = w[30:23];
        m = w[22:0];
        if (e == 8'h00 && m == 23'h0)           return {1'b0, s, 32'h0};
        if (e == 8'hFF && m == 23'h7FFFFF)      return {1'b0, s, 8'hFF, 24'h0};
        if (e == 8'h00)                         return {1'b1, s, 32'h0};
        return {1'b0, s, e - 8'd1, m, 1'b1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, score any output transfer
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                         input logic [33:0] expv, output logic acc);
        logic [33:0] ev;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h uflow %b, required no output", out_data, out_uflow);
            end else begin
                ev = exp_q.pop_front();
                check("out_data", {31'b0, out_data}, {31'b0, ev[32:0]});
                check("out_uflow", {63'b0, out_uflow}, {63'b0, ev[33]});
            end
            n_out++;
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(expv);
    endtask

    task automatic drain(input int budget);
        logic a;
        for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b1, 34'h0, a);
        check("drain_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic [31:0] d;
        logic [32:0] held;
        logic        held_set;
        int          idx, acc_cnt, full, n0;

        vecs[0]  = '{32'h4000_0000, 33'h0_7F00_0001, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 33'h1_FF00_0000, 1'b0};
        vecs[2]  = '{32'h8000_0000, 33'h1_0000_0000, 1'b0};
        vecs[3]  = '{32'h0000_0005, 33'h0_0000_0000, 1'b1};
        vecs[4]  = '{32'h7FFF_FFFF, 33'h0_FF00_0000, 1'b0};
        vecs[5]  = '{32'h7F80_0000, 33'h0_FE00_0001, 1'b0};
        vecs[6]  = '{32'h3F80_0000, 33'h0_7E00_0001, 1'b0};
        vecs[7]  = '{32'h0080_0000, 33'h0_0000_0001, 1'b0};
        vecs[8]  = '{32'h80FF_FFFF, 33'h1_00FF_FFFF, 1'b0};
        vecs[9]  = '{32'hC0A0_0000, 33'h1_8040_0001, 1'b0};
        vecs[10] = '{32'h8000_0001, 33'h1_0000_0000, 1'b1};
        vecs[11] = '{32'h7FFF_FFFE, 33'h0_FEFF_FFFD, 1'b0};
        vecs[12] = '{32'h0000_0000, 33'h0_0000_0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef FPHUB_STATUS_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_data", {31'b0, out_data}, 64'd0);
        check("rst_out_uflow", {63'b0, out_uflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

        // Latency: accepted word appears two cycles later
        cycle(1'b1, vecs[0].din, 1'b1, {vecs[0].uf, vecs[0].dout}, a);
        check("lat_accept", {63'b0, a}, 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 34'h0, a);
        check("lat_c1_out_valid", {63'b0, out_valid}, 64'd0);
        cycle(1'b0, 32'h0, 1'b1, 34'h0, a);
        check("lat_c2_out_valid", {63'b0, out_valid}, 64'd1);
        drain(10);

        // Vector table at full rate
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, vecs[i].din, 1'b1, {vecs[i].uf, vecs[i].dout}, a);
            check("table_accept", {63'b0, a}, 64'd1);
        end
        drain(10);

        // Back-pressure: 6 stalled cycles, then release
        idx = 0; held = '0; held_set = 1'b0; n0 = n_out;
        for (int c = 0; c < 6; c++) begin
            cycle(idx < 5, vecs[idx < 5 ? idx : 0].din, 1'b0,
                  {vecs[idx < 5 ? idx : 0].uf, vecs[idx < 5 ? idx : 0].dout}, a);
            if (a) idx++;
            if (out_valid && !held_set) begin
                held = out_data;
                held_set = 1'b1;
            end
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready", {63'b0, in_ready}, 64'd0);
        check("bp_out_valid", {63'b0, out_valid}, 64'd1);
        check("bp_hold", {31'b0, out_data}, {31'b0, held});
        for (int c = 0; c < 30 && idx < 5; c++) begin
            cycle(1'b1, vecs[idx].din, 1'b1, {vecs[idx].uf, vecs[idx].dout}, a);
            if (a) idx++;
        end
        drain(10);
        check("bp_out_count", n_out - n0, 5);

        // Random valid/ready over 1000 words
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
            d = $urandom;
            case ($urandom_range(0, 7))
                0: d[30:23] = 8'h00;
                1: d[30:23] = 8'hFF;
                2: d[22:0]  = 23'h0;
                3: d[30:0]  = 31'h7FFF_FFFF;
                default: ;
            endcase
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, model(d), a);
            if (a) acc_cnt++;
        end
        check("rand_words", acc_cnt, 1000);
        drain(20);

        // Sustained full rate
        n0 = n_out; full = 0;
        for (int c = 0; c < 50; c++) begin
            d = $urandom;
            cycle(1'b1, d, 1'b1, model(d), a);
            if (a) full++;
        end
        check("full_rate_accepts", full, 50);
        check("full_rate_outputs", n_out - n0, 48);
        drain(10);

        // Reset with two words in flight
        cycle(1'b1, vecs[5].din, 1'b0, {vecs[5].uf, vecs[5].dout}, a);
        cycle(1'b1, vecs[6].din, 1'b0, {vecs[6].uf, vecs[6].dout}, a);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_out_data", {31'b0, out_data}, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        n0 = n_out;
        for (int c = 0; c < 6; c++) cycle(1'b0, 32'h0, 1'b1, 34'h0, a);
        check("midrst_no_output", n_out - n0, 0);

`ifdef FPHUB_STATUS_CNT_EN
        check("cnt_out_rst", {62'b0, cnt_out}, 64'd0);
        check("cnt_uflow_rst", {62'b0, cnt_uflow}, 64'd0);
        cycle(1'b1, vecs[3].din,  1'b1, {vecs[3].uf,  vecs[3].dout},  a);
        cycle(1'b1, vecs[0].din,  1'b1, {vecs[0].uf,  vecs[0].dout},  a);
        cycle(1'b1, vecs[10].din, 1'b1, {vecs[10].uf, vecs[10].dout}, a);
        cycle(1'b1, vecs[6].din,  1'b1, {vecs[6].uf,  vecs[6].dout},  a);
        cycle(1'b1, vecs[1].din,  1'b1, {vecs[1].uf,  vecs[1].dout},  a);
        drain(10);
        cycle(1'b0, 32'h0, 1'b1, 34'h0, a);
        check("cnt_out_sat", {62'b0, cnt_out}, 64'd3);
        check("cnt_uflow_two", {62'b0, cnt_uflow}, 64'd2);
        // Clear in the same cycle as an underflow transfer
        cycle(1'b1, vecs[3].din, 1'b1, {vecs[3].uf, vecs[3].dout}, a);
        cycle(1'b0, 32'h0, 1'b0, 34'h0, a);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
        #1;
        check("clr_xfer_valid", {63'b0, out_valid}, 64'd1);
        exp_q.delete();
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        check("cnt_out_clr", {62'b0, cnt_out}, 64'd0);
        check("cnt_uflow_clr", {62'b0, cnt_uflow}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fphub_to_ieee_stream.md
Name: fphub_to_ieee_stream

Overview:
- Streaming output stage that sits directly downstream of FPHUB_mult.
- Takes HUB-format products and converts each one exactly to an IEEE-style word (same E, M+1 stored mantissa bits), so results can leave the HUB domain.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Flags and counts underflow flushes.

Parameters:
- M, 23, HUB mantissa width excluding the implicit bit; IEEE output mantissa is M+1 bits.
- E, 8, exponent width, same for input and output.
- CNT_W, 16, width of the saturating status counters (present only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  stage can accept in_data this cycle
- in_data  input  E+M+1  HUB word {sign, exp, mant}
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  E+M+2  IEEE word {sign, exp[E-1:0], mant[M:0]}
- out_uflow  output  1  the current out_data was flushed to zero by underflow

Behaviour:
- HUB value is (-1)^s * 2^(e - 2^(E-1)) * 1.m1, where the ILSB is an implicit trailing 1. IEEE bias is 2^(E-1)-1.
- Decode, in priority order:
  - HUB zero (exp = 0, mant = 0): output {s, 0, 0}, uflow = 0.
  - HUB infinity (exp all ones, mant all ones): output {s, all ones, 0}, uflow = 0.
  - exp = 0, mant != 0: IEEE exponent would be -1. Flush to {s, 0, 0}, uflow = 1.
  - Otherwise: output {s, e-1, {m,1'b1}}, exact with no rounding. exp = all ones with mant != all ones gives e-1 = 2^E-2, a normal number.
- Pipeline: stage S1 registers the decoded class plus the input fields; stage S2 registers the final word.
  - Valid bits are s1_v and s2_v.
  - s2_en = !s2_v | out_ready
  - s1_en = !s1_v | s2_en
  - in_ready = s1_en (combinational, no register)
- Transfer occurs when valid & ready are both high at a clock edge.
- Latency: 2 cycles from input acceptance to out_valid when out_ready is held high. Full throughput is 1 word per cycle.
- Stall: while out_valid = 1 and out_ready = 0, out_data and out_uflow hold stable and out_valid stays high.
  - S1 may still fill if empty. The pipe then holds 2 words and in_ready = 0.
- Simultaneous events:
  - When S2 drains and S1 holds a word in the same cycle, S1 moves to S2 and S1 accepts a new input if in_valid is high. No bubble, no loss, no duplication.
- Reset:
  - s1_v = 0, s2_v = 0, out_valid = 0, out_data = 0, out_uflow = 0, counters = 0.
  - Reset mid-operation discards in-flight words.
  - in_ready reads 1 in the first cycle after reset is released.
- Order is strictly preserved. The block never drops a word.
- While out_valid = 0, out_data is don't-care but is held at its last value.

Optional Feature:
- FPHUB_STATUS_CNT_EN.
- When defined, add these ports:
  - cnt_out (output, CNT_W): words transferred on the output.
  - cnt_uflow (output, CNT_W): transferred words with out_uflow = 1.
  - cnt_clr (input, 1): synchronous clear.
- Counters increment only on an output transfer and saturate at all ones.
- cnt_clr has priority over an increment in the same cycle; the counter becomes 0.
- rst clears the counters.
- When not defined, these ports and all counter logic are absent. Datapath behaviour is identical either way.

Test Plan:
- Basic conversion: E=8, M=23, out_ready = 1, in_data = 32'h4000_0000 (1.0 + 2^-24) -> two cycles later out_data = 33'h0_7F00_0001, out_uflow = 0.
- Special values:
  - in_data = 32'hFFFF_FFFF -> out_data = 33'h1_FF00_0000.
  - in_data = 32'h8000_0000 -> out_data = 33'h1_0000_0000, uflow = 0.
  - in_data = 32'h0000_0005 -> out_data = 33'h0_0000_0000, out_uflow = 1.
- Back-pressure: stream 5 words with out_ready = 0 for 6 cycles -> in_ready drops after 2 accepted words, out_data is held stable. Release out_ready -> all 5 words appear in order with no duplicates.
- Throughput: random in_valid/out_ready over 1000 words -> output sequence equals the golden model, and a continuous valid/ready = 1 run sustains 1 word per cycle.
- Reset: assert rst with 2 words in flight -> next cycle out_valid = 0, out_data = 0, and neither word ever appears.
- Counters (FPHUB_STATUS_CNT_EN, CNT_W = 2): 5 transfers including 2 underflows -> cnt_out = 3 (saturated), cnt_uflow = 2. cnt_clr asserted in the same cycle as a transfer -> counters = 0.
